// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, word/state types and round helper functions
package sha256_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_t;

   localparam word_t K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam word_t IV256 [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam word_t IV224 [0:7] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

   // Flattened IVs, H0 in the top word, matching the a..h state packing
   localparam logic [255:0] IV256_FLAT = {IV256[0], IV256[1], IV256[2], IV256[3],
                                          IV256[4], IV256[5], IV256[6], IV256[7]};
   localparam logic [255:0] IV224_FLAT = {IV224[0], IV224[1], IV224[2], IV224[3],
                                          IV224[4], IV224[5], IV224[6], IV224[7]};

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t ch(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic word_t maj(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic word_t bsig0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t bsig1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t ssig0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t ssig1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 round, state packed a..h with a in [255:224]
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] st_in,
   input  word_t        kt,
   input  word_t        wt,
   output logic [255:0] st_out
);

   word_t a, b, c, d, e, f, g, h;
   word_t t1, t2;

   assign {a, b, c, d, e, f, g, h} = st_in;
   assign t1 = h + bsig1(e) + ch(e, f, g) + kt + wt;
   assign t2 = bsig0(a) + maj(a, b, c);
   assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_core.sv
// rtl/sha256_stream_core.sv - iterative SHA-256 block engine with chaining; optional SHA-224 via SHA224_MODE_EN
module sha256_stream_core
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit BIG_ENDIAN_IN    = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_first,
   input  logic         in_last,
   input  logic         mode224,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_digest,
   output logic         busy
);

   localparam int         R     = ROUNDS_PER_CYCLE;
   localparam logic [5:0] RSTEP = 6'(R);
   localparam logic [5:0] RLAST = 6'(64 - R);

   state_t       state, state_nx;
   word_t        win [0:15];
   word_t        ext [0:15+R];
   word_t        blk_w [0:15];
   logic [255:0] chain [0:R];
   logic [255:0] work, hreg, base, hsum, iv_acc, iv_base, dig_nx;
   logic [5:0]   rnd;
   logic         last_r, first_r;

`ifdef SHA224_MODE_EN
   logic mode_r;

   // Digest width/IV selection is fixed by mode224 at the first block of a message
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         mode_r <= 1'b0;
      else if (en && state == IDLE && in_valid && in_first)
         mode_r <= mode224;
   end

   assign iv_acc  = mode224 ? IV224_FLAT : IV256_FLAT;
   assign iv_base = mode_r  ? IV224_FLAT : IV256_FLAT;
   assign dig_nx  = mode_r  ? {hreg[255:32], 32'h0} : hreg;
`else
   logic unused_mode224;
   assign unused_mode224 = mode224;
   assign iv_acc  = IV256_FLAT;
   assign iv_base = IV256_FLAT;
   assign dig_nx  = hreg;
`endif

   // Split the incoming block into W0..W15 according to the configured word order
   always_comb begin
      for (int i = 0; i < 16; i++)
         blk_w[i] = BIG_ENDIAN_IN ? in_block[511-32*i -: 32] : in_block[32*i +: 32];
   end

   // Message schedule: window holds W[t..t+15]; extend by R words for this cycle
   always_comb begin
      for (int i = 0; i < 16; i++)
         ext[i] = win[i];
      for (int j = 0; j < R; j++)
         ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
   end

   assign chain[0] = work;

   for (genvar j = 0; j < R; j++) begin : g_round
      sha256_round u_round (
         .st_in  (chain[j]),
         .kt     (K[rnd + 6'(j)]),
         .wt     (ext[j]),
         .st_out (chain[j+1])
      );
   end

   // Feed-forward add; the base is the IV when the block started a message
   always_comb begin
      base = first_r ? iv_base : hreg;
      for (int i = 0; i < 8; i++)
         hsum[255-32*i -: 32] = base[255-32*i -: 32] + work[255-32*i -: 32];
   end

   // State register; en=0 freezes the FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else if (en)
         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = ROUND;
         ROUND:   if (rnd == RLAST) state_nx = UPDATE;
         UPDATE:  state_nx = last_r ? DONE : IDLE;
         DONE:    if (out_valid && out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      in_ready = (state == IDLE);
      busy     = (state != IDLE);
   end

   // Working variables, schedule window, round counter and chaining value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++)
            win[i] <= '0;
         work    <= '0;
         hreg    <= IV256_FLAT;
         rnd     <= '0;
         last_r  <= 1'b0;
         first_r <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: if (in_valid) begin
               for (int i = 0; i < 16; i++)
                  win[i] <= blk_w[i];
               work    <= in_first ? iv_acc : hreg;
               last_r  <= in_last;
               first_r <= in_first;
               rnd     <= '0;
            end
            ROUND: begin
               for (int i = 0; i < 16; i++)
                  win[i] <= ext[i+R];
               work <= chain[R];
               rnd  <= rnd + RSTEP;
            end
            UPDATE: hreg <= hsum;
            DONE: if (out_valid && out_ready) hreg <= IV256_FLAT;
            default: ;
         endcase
      end
   end

   // Registered digest presentation: captured on the first DONE cycle, held until taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_digest <= '0;
      end else if (en && state == DONE) begin
         if (!out_valid) begin
            out_valid  <= 1'b1;
            out_digest <= dig_nx;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
